// File: rtl/seven_seg_capture_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_capture_pkg
// Shared definitions for the seven-segment capture path and the display driver:
// the hi/lo phase enum and the 16-entry segment pattern table.
// Pattern bit order is {g,f,e,d,c,b,a}, active-high. Entry N is the pattern
// shown for hex digit N.
// -----------------------------------------------------------------------------
package seven_seg_capture_pkg;

    typedef enum logic {
        HI = 1'b0,
        LO = 1'b1
    } phase_e;

    localparam int NUM_PATTERNS = 16;

    // Listed from F down to 0 so that SEG_TABLE[n] is the pattern for digit n.
    localparam logic [NUM_PATTERNS-1:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        return SEG_TABLE[hex];
    endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// -----------------------------------------------------------------------------
// seven_seg_decode
// Combinational reverse lookup of a seven-segment pattern into its hex value.
// Ports:
//   seg  in  7  pattern {g,f,e,d,c,b,a}
//   hex  out 4  decoded value (0 when the pattern is not in the table)
//   ok   out 1  high when the pattern matched a table entry
// -----------------------------------------------------------------------------
module seven_seg_decode
    import seven_seg_capture_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] hex,
    output logic       ok
);

    // Table entries are all distinct, so at most one iteration can match.
    always_comb begin
        hex = 4'h0;
        ok  = 1'b0;
        for (int i = 0; i < NUM_PATTERNS; i++) begin
            if (seg == hex_to_seg(4'(i))) begin
                hex = 4'(i);
                ok  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seven_seg_capture.sv
// -----------------------------------------------------------------------------
// seven_seg_capture
// Reassembles a two-digit multiplexed seven-segment stream into a digit pair,
// decodes both digits to hex and supervises the strobe period.
// Ports:
//   clk         in   1   clock, rising edge
//   rst_n       in   1   asynchronous active-low reset
//   segment     in   7   multiplexed segment bus, valid when sig=1
//   sig         in   1   one-cycle strobe per digit (hi digit first)
//   both7seg    out  14  {hi pattern, lo pattern} of the last complete pair
//   pair_valid  out  1   pulse, one cycle after the lo strobe
//   hi_hex      out  4   decoded hi digit
//   lo_hex      out  4   decoded lo digit
//   hex_ok      out  2   [1]=hi pattern legal, [0]=lo pattern legal
//   period_err  out  1   pulse when a strobe gap is outside FREQ+-TOL
//   timeout     out  1   level, no strobe for more than FREQ+TOL cycles
// -----------------------------------------------------------------------------
module seven_seg_capture
    import seven_seg_capture_pkg::*;
#(
    parameter int FREQ  = 17500,
    parameter int CBITS = 15,
    parameter int TOL   = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  segment,
    input  logic        sig,
    output logic [13:0] both7seg,
    output logic        pair_valid,
    output logic [3:0]  hi_hex,
    output logic [3:0]  lo_hex,
    output logic [1:0]  hex_ok,
    output logic        period_err,
    output logic        timeout
);

    localparam int MIN_GAP_I = (FREQ > TOL) ? (FREQ - TOL) : 0;

    localparam logic [CBITS-1:0] MIN_GAP = CBITS'(MIN_GAP_I);
    localparam logic [CBITS-1:0] MAX_GAP = CBITS'(FREQ + TOL);
    localparam logic [CBITS-1:0] LIMIT   = CBITS'(FREQ + TOL + 1);

    phase_e             phase_q,      phase_d;
    logic [CBITS-1:0]   cnt_q,        cnt_d;
    logic               seen_q,       seen_d;
    logic [6:0]         hi_seg_q,     hi_seg_d;
    logic [13:0]        both7seg_q,   both7seg_d;
    logic [3:0]         hi_hex_q,     hi_hex_d;
    logic [3:0]         lo_hex_q,     lo_hex_d;
    logic [1:0]         hex_ok_q,     hex_ok_d;
    logic               pair_valid_q, pair_valid_d;
    logic               period_err_q, period_err_d;
    logic               timeout_q,    timeout_d;

    logic [3:0]         hi_dec_hex;
    logic               hi_dec_ok;
    logic [3:0]         lo_dec_hex;
    logic               lo_dec_ok;

    // The hi digit is decoded from its held register, the lo digit straight
    // from the bus, so both results are ready in the lo strobe cycle.
    seven_seg_decode u_hi_decode (
        .seg (hi_seg_q),
        .hex (hi_dec_hex),
        .ok  (hi_dec_ok)
    );

    seven_seg_decode u_lo_decode (
        .seg (segment),
        .hex (lo_dec_hex),
        .ok  (lo_dec_ok)
    );

    always_comb begin
        phase_d      = phase_q;
        cnt_d        = cnt_q;
        seen_d       = seen_q;
        hi_seg_d     = hi_seg_q;
        both7seg_d   = both7seg_q;
        hi_hex_d     = hi_hex_q;
        lo_hex_d     = lo_hex_q;
        hex_ok_d     = hex_ok_q;
        pair_valid_d = 1'b0;
        period_err_d = 1'b0;
        timeout_d    = timeout_q;

        if (sig) begin
            // cnt_q holds the number of non-strobe cycles since the last
            // strobe. The strobe takes priority over a threshold crossing in
            // the same cycle, so the counter never reaches LIMIT here.
            cnt_d        = '0;
            seen_d       = 1'b1;
            timeout_d    = 1'b0;
            period_err_d = seen_q && ((cnt_q < MIN_GAP) || (cnt_q > MAX_GAP));

            if (phase_q == HI) begin
                hi_seg_d = segment;
                phase_d  = LO;
            end else begin
                both7seg_d   = {hi_seg_q, segment};
                hi_hex_d     = hi_dec_hex;
                lo_hex_d     = lo_dec_hex;
                hex_ok_d     = {hi_dec_ok, lo_dec_ok};
                pair_valid_d = 1'b1;
                phase_d      = HI;
            end
        end else if (cnt_q != LIMIT) begin
            cnt_d = cnt_q + 1'b1;
            // Reaching LIMIT abandons any half-captured pair and forgets the
            // previous strobe so the next one is not judged against it.
            if (cnt_q == MAX_GAP) begin
                timeout_d = 1'b1;
                phase_d   = HI;
                seen_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q      <= HI;
            cnt_q        <= '0;
            seen_q       <= 1'b0;
            hi_seg_q     <= '0;
            both7seg_q   <= '0;
            hi_hex_q     <= '0;
            lo_hex_q     <= '0;
            hex_ok_q     <= '0;
            pair_valid_q <= 1'b0;
            period_err_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            seen_q       <= seen_d;
            hi_seg_q     <= hi_seg_d;
            both7seg_q   <= both7seg_d;
            hi_hex_q     <= hi_hex_d;
            lo_hex_q     <= lo_hex_d;
            hex_ok_q     <= hex_ok_d;
            pair_valid_q <= pair_valid_d;
            period_err_q <= period_err_d;
            timeout_q    <= timeout_d;
        end
    end

    assign both7seg   = both7seg_q;
    assign hi_hex     = hi_hex_q;
    assign lo_hex     = lo_hex_q;
    assign hex_ok     = hex_ok_q;
    assign pair_valid = pair_valid_q;
    assign period_err = period_err_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_seven_seg_capture.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_capture
// Two instances: u_big runs at the default FREQ=17500/TOL=0 for the long
// directed scenarios, u_small runs at FREQ=12/TOL=2 for the pattern table and
// the randomized run against a behavioural model.
// -----------------------------------------------------------------------------
module tb_seven_seg_capture;

    localparam int FREQ_S  = 12;
    localparam int TOL_S   = 2;
    localparam int CBITS_S = 5;
    localparam int LIM_S   = FREQ_S + TOL_S + 1;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;

    logic [6:0]  seg_b, seg_s;
    logic        sig_b, sig_s;
    logic [13:0] both_b, both_s;
    logic        pv_b, pv_s, pe_b, pe_s, to_b, to_s;
    logic [3:0]  hh_b, lh_b, hh_s, lh_s;
    logic [1:0]  ok_b, ok_s;

    int n_checks = 0;
    int n_fails  = 0;

    // Independent copy of the digit patterns, index = hex value.
    logic [6:0] pat [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct packed {
        logic [6:0] hi_seg;
        logic [6:0] lo_seg;
        logic [3:0] hh;
        logic [3:0] lh;
        logic [1:0] ok;
    } vec_t;

    vec_t vecs [11];

    always #5 clk = ~clk;

    seven_seg_capture u_big (
        .clk        (clk),
        .rst_n      (rst_n),
        .segment    (seg_b),
        .sig        (sig_b),
        .both7seg   (both_b),
        .pair_valid (pv_b),
        .hi_hex     (hh_b),
        .lo_hex     (lh_b),
        .hex_ok     (ok_b),
        .period_err (pe_b),
        .timeout    (to_b)
    );

    seven_seg_capture #(.FREQ(FREQ_S), .CBITS(CBITS_S), .TOL(TOL_S)) u_small (
        .clk        (clk),
        .rst_n      (rst_n),
        .segment    (seg_s),
        .sig        (sig_s),
        .both7seg   (both_s),
        .pair_valid (pv_s),
        .hi_hex     (hh_s),
        .lo_hex     (lh_s),
        .hex_ok     (ok_s),
        .period_err (pe_s),
        .timeout    (to_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #3;
        check("reset_big_outputs", {5'b0, both_b, hh_b, lh_b, ok_b, pv_b, pe_b, to_b}, 32'h0);
        check("reset_small_outputs", {5'b0, both_s, hh_s, lh_s, ok_s, pv_s, pe_s, to_s}, 32'h0);
        rst_n = 1'b1;
    endtask

    task automatic idle_b(input int n, output int to_cnt, output int pe_cnt);
        to_cnt = 0;
        pe_cnt = 0;
        sig_b  = 1'b0;
        for (int i = 0; i < n; i++) begin
            seg_b = 7'($urandom);
            tick();
            if (to_b) to_cnt++;
            if (pe_b) pe_cnt++;
        end
        seg_b = 7'h00;
    endtask

    task automatic strobe_b(input logic [6:0] s);
        sig_b = 1'b1;
        seg_b = s;
        tick();
        sig_b = 1'b0;
        seg_b = 7'h00;
    endtask

    task automatic idle_s(input int n);
        sig_s = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic strobe_s(input logic [6:0] s);
        sig_s = 1'b1;
        seg_s = s;
        tick();
        sig_s = 1'b0;
        seg_s = 7'h00;
    endtask

    function automatic void model_decode(input logic [6:0] s, output logic [3:0] h, output logic ok);
        h  = 4'h0;
        ok = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (pat[4'(i)] == s) begin
                h  = 4'(i);
                ok = 1'b1;
            end
        end
    endfunction

    // Watchdog: the whole run is a few hundred thousand ns.
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int to_cnt, pe_cnt, first_to;
        // behavioural model state for the random run
        int         since, left;
        bit         seen, ph_lo;
        logic [6:0] m_hi, s;
        logic [13:0] m_pair;
        logic [3:0] m_hh, m_lh, idx;
        logic       m_okh, m_okl, m_pv, m_pe, m_to;
        logic [1:0] m_ok;

        sig_b = 1'b0; seg_b = 7'h00;
        sig_s = 1'b0; seg_s = 7'h00;

        vecs[0]  = {7'h3F, 7'h06, 4'h0, 4'h1, 2'b11};
        vecs[1]  = {7'h5B, 7'h4F, 4'h2, 4'h3, 2'b11};
        vecs[2]  = {7'h66, 7'h6D, 4'h4, 4'h5, 2'b11};
        vecs[3]  = {7'h7D, 7'h07, 4'h6, 4'h7, 2'b11};
        vecs[4]  = {7'h7F, 7'h6F, 4'h8, 4'h9, 2'b11};
        vecs[5]  = {7'h77, 7'h7C, 4'hA, 4'hB, 2'b11};
        vecs[6]  = {7'h39, 7'h5E, 4'hC, 4'hD, 2'b11};
        vecs[7]  = {7'h79, 7'h71, 4'hE, 4'hF, 2'b11};
        vecs[8]  = {7'h00, 7'h7F, 4'h0, 4'h8, 2'b01};
        vecs[9]  = {7'h3F, 7'h7E, 4'h0, 4'h0, 2'b10};
        vecs[10] = {7'h40, 7'h01, 4'h0, 4'h0, 2'b00};

        // Reset state while rst_n is held low.
        #23;
        check("reset_big_outputs", {5'b0, both_b, hh_b, lh_b, ok_b, pv_b, pe_b, to_b}, 32'h0);
        check("reset_small_outputs", {5'b0, both_s, hh_s, lh_s, ok_s, pv_s, pe_s, to_s}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Pattern table on the small instance, nominal gaps throughout.
        for (int v = 0; v < 11; v++) begin
            idle_s(FREQ_S);
            strobe_s(vecs[v].hi_seg);
            check("table_hi_no_pair", {31'b0, pv_s}, 32'h0);
            idle_s(FREQ_S);
            strobe_s(vecs[v].lo_seg);
            check("table_pair", {both_s, hh_s, lh_s, ok_s, pv_s, pe_s},
                  {vecs[v].hi_seg, vecs[v].lo_seg, vecs[v].hh, vecs[v].lh, vecs[v].ok, 1'b1, 1'b0});
        end

        // Randomized stream on the small instance against a behavioural model.
        pulse_reset();
        since = 0; seen = 0; ph_lo = 0; left = 3;
        m_hi = '0; m_pair = '0; m_hh = '0; m_lh = '0; m_ok = '0;
        m_pv = 0; m_pe = 0; m_to = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 1) == 1) begin
                idx = 4'($urandom_range(0, 15));
                s = pat[idx];
            end else begin
                s = 7'($urandom);
            end
            seg_s = s;
            if (left == 0) begin
                sig_s = 1'b1;
                case ($urandom_range(0, 3))
                    0: left = 0;
                    1: left = $urandom_range(FREQ_S - TOL_S, FREQ_S + TOL_S);
                    2: left = $urandom_range(0, LIM_S + 5);
                    default: left = $urandom_range(FREQ_S - TOL_S - 2, FREQ_S + TOL_S + 2);
                endcase
                // model: gap rule, then hi/lo pairing
                m_pe = seen && (since < FREQ_S - TOL_S || since > FREQ_S + TOL_S);
                if (ph_lo) begin
                    m_pair = {m_hi, s};
                    model_decode(m_hi, m_hh, m_okh);
                    model_decode(s, m_lh, m_okl);
                    m_ok = {m_okh, m_okl};
                    m_pv = 1'b1;
                    ph_lo = 0;
                end else begin
                    m_hi = s;
                    m_pv = 1'b0;
                    ph_lo = 1;
                end
                since = 0;
                seen  = 1;
                m_to  = 1'b0;
            end else begin
                sig_s = 1'b0;
                left--;
                since++;
                m_pe = 1'b0;
                m_pv = 1'b0;
                if (since >= LIM_S) begin
                    m_to  = 1'b1;
                    ph_lo = 0;
                    seen  = 0;
                end
            end
            tick();
            check("random_cycle", {5'b0, both_s, hh_s, lh_s, ok_s, pv_s, pe_s, to_s},
                  {5'b0, m_pair, m_hh, m_lh, m_ok, m_pv, m_pe, m_to});
        end
        sig_s = 1'b0;
        seg_s = 7'h00;

        // Nominal pair 3F/06 at FREQ=17500; lo strobe lands on the cycle the
        // counter would reach the timeout threshold.
        pulse_reset();
        idle_b(3, to_cnt, pe_cnt);
        strobe_b(7'h3F);
        idle_b(17500, to_cnt, pe_cnt);
        check("no_timeout_before_threshold_strobe", to_cnt, 0);
        strobe_b(7'h06);
        check("pair_1f86_both7seg", {18'b0, both_b}, 32'h1F86);
        check("pair_1f86_hex", {24'b0, hh_b, lh_b}, 32'h01);
        check("pair_1f86_ok", {30'b0, ok_b}, 32'h3);
        check("pair_1f86_flags", {29'b0, pv_b, pe_b, to_b}, 32'h4);
        idle_b(1, to_cnt, pe_cnt);
        check("pair_valid_one_pulse", {31'b0, pv_b}, 32'h0);
        check("both7seg_hold", {18'b0, both_b}, 32'h1F86);

        // Illegal hi pattern with lo 7F.
        pulse_reset();
        idle_b(3, to_cnt, pe_cnt);
        strobe_b(7'h00);
        idle_b(3, to_cnt, pe_cnt);
        strobe_b(7'h7F);
        check("illegal_hi_both7seg", {18'b0, both_b}, 32'h007F);
        check("illegal_hi_decode", {22'b0, hh_b, lh_b, ok_b}, {22'b0, 4'h0, 4'h8, 2'b01});

        // Short gap of 17499 with TOL=0.
        pulse_reset();
        idle_b(3, to_cnt, pe_cnt);
        strobe_b(7'h3F);
        idle_b(17499, to_cnt, pe_cnt);
        check("short_gap_no_early_err", pe_cnt, 0);
        strobe_b(7'h5B);
        check("short_gap_err_and_pair", {16'b0, both_b, pv_b, pe_b}, {16'b0, 14'h1FDB, 1'b1, 1'b1});
        idle_b(1, to_cnt, pe_cnt);
        check("short_gap_err_one_pulse", {31'b0, pe_b}, 32'h0);

        // Strobes stop after a hi digit: timeout after exactly 17501 cycles.
        strobe_b(7'h4F);
        first_to = 0;
        sig_b = 1'b0;
        for (int k = 1; k <= 17510; k++) begin
            tick();
            if (to_b) begin
                first_to = k;
                break;
            end
        end
        check("timeout_latency", first_to, 17501);
        idle_b(5, to_cnt, pe_cnt);
        check("timeout_is_level", to_cnt, 5);
        strobe_b(7'h66);
        check("after_timeout_hi", {16'b0, both_b, pv_b, pe_b, to_b}, {15'b0, 14'h1FDB, 3'b000});
        idle_b(2, to_cnt, pe_cnt);
        strobe_b(7'h7D);
        check("after_timeout_pair", {16'b0, both_b, pv_b, to_b}, {16'b0, 14'h337D, 1'b1, 1'b0});
        check("after_timeout_decode", {22'b0, hh_b, lh_b, ok_b}, {22'b0, 4'h4, 4'h6, 2'b11});

        // Reset between hi and lo strobes discards the hi digit.
        strobe_b(7'h06);
        pulse_reset();
        strobe_b(7'h5B);
        check("post_reset_first_is_hi", {17'b0, both_b, pv_b}, 32'h0);
        idle_b(3, to_cnt, pe_cnt);
        strobe_b(7'h4F);
        check("post_reset_pair", {16'b0, both_b, pv_b, to_b}, {16'b0, 14'h2DCF, 1'b1, 1'b0});
        check("post_reset_decode", {22'b0, hh_b, lh_b, ok_b}, {22'b0, 4'h2, 4'h3, 2'b11});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/seven_seg_capture.md
SEVEN_SEG_CAPTURE -- requirements
Module: seven_seg_capture

Interface
REQ-001 SHALL provide parameter FREQ, default 17500: expected number of non-strobe cycles between consecutive sig strobes.
REQ-002 SHALL provide parameter CBITS, default 15: gap counter width; CBITS SHALL hold FREQ+TOL+1.
REQ-003 SHALL provide parameter TOL, default 0: allowed ± deviation of the gap from FREQ before a period error is flagged.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 segment  input  7  multiplexed segment bus {g,f,e,d,c,b,a}, active-high, meaningful only when sig=1.
REQ-007 sig  input  1  one-cycle strobe marking a new digit on segment.
REQ-008 both7seg  output  14  reconstructed pair: {hi digit, lo digit}.
REQ-009 pair_valid  output  1  one-cycle pulse when both7seg updates.
REQ-010 hi_hex, lo_hex  output  4 each  hex value decoded from each captured digit.
REQ-011 hex_ok  output  2  [1]=hi pattern legal, [0]=lo pattern legal.
REQ-012 period_err  output  1  one-cycle pulse when a strobe gap falls outside FREQ±TOL.
REQ-013 timeout  output  1  level; high while no strobe has arrived for more than FREQ+TOL cycles.

Function
REQ-014 Phase FSM SHALL have states HI and LO; it is HI after reset and after timeout.
REQ-015 In HI, a cycle with sig=1 SHALL latch segment into an internal hi register and move to LO.
REQ-016 In LO, a cycle with sig=1 SHALL load both7seg={hi register, segment}, update the decode outputs, pulse pair_valid on the next cycle (1-cycle latency), and move to HI.
REQ-017 both7seg, hi_hex, lo_hex and hex_ok SHALL hold their value between pair updates.
REQ-018 Decode SHALL map the standard patterns to hex: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
REQ-019 Any other pattern SHALL give hex value 0 with the matching hex_ok bit cleared.
REQ-020 The gap counter SHALL clear to 0 in every sig cycle, increment in every non-sig cycle, and saturate at FREQ+TOL+1.
REQ-021 On a sig cycle, if a previous strobe has been seen since reset/timeout and the gap is outside [FREQ-TOL, FREQ+TOL], period_err SHALL pulse on the next cycle; phase handling is unaffected.
REQ-022 When the counter reaches FREQ+TOL+1, timeout SHALL assert and the FSM SHALL return to HI; the next strobe SHALL clear timeout, be treated as a hi digit and raise no period_err.
REQ-023 If sig arrives in the same cycle the counter would reach the timeout threshold, the strobe wins: no timeout and normal capture.
REQ-024 sig held high for several cycles SHALL be treated as one strobe per cycle, with no edge detection.

Reset
REQ-025 While rst_n=0: both7seg=0, hi_hex=0, lo_hex=0, hex_ok=0, pair_valid=0, period_err=0, timeout=0, FSM=HI, gap counter=0, "strobe seen" flag clear.
REQ-026 Reset asserted mid-pair SHALL discard a captured but unpaired hi digit.

Structure
REQ-027 A shared package SHALL hold the phase enum (HI, LO) and the 16-entry pattern constants, so that the display driver and this block use the same table.
REQ-028 One sub-module, seven_seg_decode (combinational, 7-bit pattern in, 4-bit hex plus ok out), SHALL be instantiated twice.

Verification
REQ-029 Driver model with FREQ=17500, pair 0x1F86 (hi 3F, lo 06): after two strobes both7seg=0x1F86, hi_hex=0, lo_hex=1, hex_ok=2'b11, one pair_valid pulse, no period_err.
REQ-030 Illegal hi pattern 0x00 with lo 0x7F: hi_hex=0, lo_hex=8, hex_ok=2'b01.
REQ-031 Second strobe at gap 17499 with TOL=0: period_err pulses once and the pair is still captured.
REQ-032 Strobes stop after the hi digit: timeout asserts exactly 17501 cycles after the last strobe; the next strobe 0x66 is taken as hi; both7seg stays unchanged until a lo strobe arrives.
REQ-033 rst_n pulsed low between the hi and lo strobes: all outputs read 0, and the following strobe is captured as hi.
REQ-034 sig asserted on the cycle where the counter would reach 17501: no timeout and normal capture (REQ-023).
